// File: rtl/jtag_scan_pkg.sv
// rtl/jtag_scan_pkg.sv - shared types and TMS sequences for the JTAG scan master
package jtag_scan_pkg;

    typedef enum logic [2:0] {
        RST_SEQ,
        IDLE,
        PRE,
        SHIFT,
        POST
    } state_t;

    // TMS sequences are applied LSB first, one bit per TCK cycle.
    // The *_LAST values are the index of the final bit of each sequence.
    localparam logic [7:0] TMS_RST     = 8'b0001_1111;  // 1,1,1,1,1,0 -> TLR then RTI
    localparam logic [2:0] RST_LAST    = 3'd5;
    localparam logic [7:0] TMS_PRE_DR  = 8'b0000_0001;  // 1,0,0 -> Shift-DR
    localparam logic [2:0] PRE_DR_LAST = 3'd2;
    localparam logic [7:0] TMS_PRE_IR  = 8'b0000_0011;  // 1,1,0,0 -> Shift-IR
    localparam logic [2:0] PRE_IR_LAST = 3'd3;
    localparam logic [7:0] TMS_POST    = 8'b0000_0001;  // 1,0 -> Update-xR, RTI
    localparam logic [2:0] POST_LAST   = 3'd1;

    // Gowin IDCODE, handy for benches driving a behavioural TAP.
    localparam logic [31:0] GOWIN_IDCODE = 32'h1100_481B;

    function automatic logic tms_bit(input logic [7:0] seq, input logic [2:0] idx);
        return seq[idx];
    endfunction

endpackage

// File: rtl/jtag_scan_master_tck_gen.sv
// rtl/jtag_scan_master_tck_gen.sv - TCK divider with phase strobes
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : run the divider; low holds TCK low and clears the count
//   tck_o       : generated TCK, CLK_DIV cycles low then CLK_DIV cycles high
//   fall_stb    : TCK falls at the end of this cycle (load next TMS/TDI)
//   sample_stb  : last cycle of the high phase (sample synchronised TDO)
//   cyc_done    : a full TCK cycle completes at the end of this cycle
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck_o,
    output logic fall_stb,
    output logic sample_stb,
    output logic cyc_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end;

    assign phase_end = en & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tck_o <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            tck_o <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tck_o <= ~tck_o;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A TCK cycle ends with its falling edge, so the three strobes share one
    // cycle; they stay separate so each consumer names what it waits for.
    assign fall_stb   = phase_end & tck_o;
    assign sample_stb = phase_end & tck_o;
    assign cyc_done   = phase_end & tck_o;

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - on-chip JTAG initiator for IR/DR scans and TAP reset
//
// Ports:
//   sys_clk, sys_rst_n          : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake, accepted on valid & ready
//   cmd_reset, cmd_ir           : TAP reset request / IR (1) or DR (0) scan
//   cmd_len, cmd_data           : scan length 1..MAX_LEN, TDI bits LSB first
//   rsp_valid, rsp_err, rsp_data: completion pulse, illegal-length flag, TDO bits
//   busy                        : a scan or reset sequence is running
//   tck_o, tms_o, tdi_o, tdo_i  : JTAG pins (tdo_i asynchronous)
module jtag_scan_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_reset,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    import jtag_scan_pkg::*;

    localparam logic [MAX_LEN-1:0] MASK_FIRST = {{(MAX_LEN-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [LEN_W-1:0]   bit_cnt, bit_cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               ir_q, ir_n;
    logic               rst_cmd_q, rst_cmd_n;
    logic [MAX_LEN-1:0] sh_q, sh_n;
    logic [MAX_LEN-1:0] cap_q, cap_n;
    logic [MAX_LEN-1:0] mask_q, mask_n;
    logic [MAX_LEN-1:0] rsp_data_n;
    logic               rsp_valid_n, rsp_err_n;
    logic               tms_n, tdi_n;
    logic               cmd_accept;
    logic               div_en;
    logic [1:0]         tdo_sync;
    logic               tdo_s;
    logic               fall_stb, sample_stb, cyc_done;
    logic [7:0]         pre_seq;
    logic [2:0]         pre_last;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .en         (div_en),
        .tck_o      (tck_o),
        .fall_stb   (fall_stb),
        .sample_stb (sample_stb),
        .cyc_done   (cyc_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tdo_sync <= 2'b00;
        else            tdo_sync <= {tdo_sync[0], tdo_i};
    end
    assign tdo_s = tdo_sync[1];

    assign pre_seq  = ir_q ? TMS_PRE_IR  : TMS_PRE_DR;
    assign pre_last = ir_q ? PRE_IR_LAST : PRE_DR_LAST;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        len_n       = len_q;
        ir_n        = ir_q;
        rst_cmd_n   = rst_cmd_q;
        sh_n        = sh_q;
        cap_n       = cap_q;
        mask_n      = mask_q;
        rsp_valid_n = 1'b0;
        rsp_err_n   = rsp_err;
        rsp_data_n  = rsp_data;
        tms_n       = tms_o;
        tdi_n       = tdi_o;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        div_en      = 1'b1;
        cmd_accept  = 1'b0;

        case (state)
            RST_SEQ: begin
                if (cyc_done) begin
                    if (bit_cnt == LEN_W'(RST_LAST)) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        tms_n     = 1'b0;
                        tdi_n     = 1'b0;
                        // Only a commanded reset answers; power-on reset is silent.
                        if (rst_cmd_q) begin
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = 1'b0;
                            rsp_data_n  = '0;
                        end
                        rst_cmd_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + LEN_W'(1);
                        tms_n     = tms_bit(TMS_RST, bit_cnt[2:0] + 3'd1);
                        tdi_n     = 1'b0;
                    end
                end
            end

            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                div_en    = 1'b0;
                tdi_n     = 1'b0;
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    if (cmd_reset) begin
                        state_n   = RST_SEQ;
                        bit_cnt_n = '0;
                        rst_cmd_n = 1'b1;
                        tms_n     = 1'b1;
                    end else if ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN))) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                        tms_n       = 1'b0;
                    end else begin
                        state_n   = PRE;
                        bit_cnt_n = '0;
                        len_n     = cmd_len;
                        ir_n      = cmd_ir;
                        sh_n      = cmd_data;
                        cap_n     = '0;
                        mask_n    = MASK_FIRST;
                        tms_n     = 1'b1;
                    end
                end
            end

            PRE: begin
                if (cyc_done) begin
                    if (bit_cnt == LEN_W'(pre_last)) begin
                        state_n   = SHIFT;
                        bit_cnt_n = '0;
                        tms_n     = (len_q == LEN_W'(1));
                        tdi_n     = sh_q[0];
                    end else begin
                        bit_cnt_n = bit_cnt + LEN_W'(1);
                        tms_n     = tms_bit(pre_seq, bit_cnt[2:0] + 3'd1);
                        tdi_n     = 1'b0;
                    end
                end
            end

            SHIFT: begin
                // mask_q walks one-hot from bit 0 so captured bit k lands at k.
                if (sample_stb) cap_n = cap_q | (mask_q & {MAX_LEN{tdo_s}});
                if (cyc_done) begin
                    mask_n = mask_q << 1;
                    sh_n   = sh_q >> 1;
                    if (bit_cnt == len_q - LEN_W'(1)) begin
                        state_n   = POST;
                        bit_cnt_n = '0;
                        tms_n     = 1'b1;
                        tdi_n     = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + LEN_W'(1);
                        tms_n     = (bit_cnt + LEN_W'(2) == len_q);
                        tdi_n     = sh_q[1];
                    end
                end
            end

            POST: begin
                if (cyc_done) begin
                    if (bit_cnt == LEN_W'(POST_LAST)) begin
                        state_n     = IDLE;
                        bit_cnt_n   = '0;
                        tms_n       = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b0;
                        rsp_data_n  = cap_q;
                    end else begin
                        bit_cnt_n = bit_cnt + LEN_W'(1);
                        tms_n     = tms_bit(TMS_POST, bit_cnt[2:0] + 3'd1);
                    end
                    tdi_n = 1'b0;
                end
            end

            default: state_n = RST_SEQ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= RST_SEQ;
            bit_cnt   <= '0;
            len_q     <= '0;
            ir_q      <= 1'b0;
            rst_cmd_q <= 1'b0;
            sh_q      <= '0;
            cap_q     <= '0;
            mask_q    <= MASK_FIRST;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            len_q     <= len_n;
            ir_q      <= ir_n;
            rst_cmd_q <= rst_cmd_n;
            sh_q      <= sh_n;
            cap_q     <= cap_n;
            mask_q    <= mask_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_data  <= rsp_data_n;
        end
    end

    // TMS/TDI change with the TCK falling edge, or on accept so the first
    // bit is stable for the whole first low phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tms_o <= 1'b1;
            tdi_o <= 1'b0;
        end else if (fall_stb || cmd_accept) begin
            tms_o <= tms_n;
            tdi_o <= tdi_n;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - self-checking bench for jtag_scan_master with a behavioural TAP
module tb_jtag_scan_master;

    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam logic [31:0] IDCODE     = 32'h1100_481B;
    localparam logic [7:0]  INS_IDCODE = 8'h11;
    localparam logic [7:0]  INS_BYPASS = 8'hFF;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_reset = 1'b0;
    logic               cmd_ir = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_err;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck_o;
    logic               tms_o;
    logic               tdi_o;
    logic               tdo_i = 1'b0;

    jtag_scan_master #(
        .CLK_DIV (CLK_DIV),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reset (cmd_reset),
        .cmd_ir    (cmd_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck_o     (tck_o),
        .tms_o     (tms_o),
        .tdi_o     (tdi_o),
        .tdo_i     (tdo_i)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Free-running observation counters.
    int sys_cyc = 0;
    int tck_total = 0;
    int last_rise = 0;
    int tck_period = 0;
    int rsp_pulses = 0;
    logic [7:0] tms_log = 8'h00;

    always @(posedge sys_clk) sys_cyc++;
    always @(negedge sys_clk) if (rsp_valid === 1'b1) rsp_pulses++;
    always @(posedge tck_o) begin
        tck_total++;
        tck_period = sys_cyc - last_rise;
        last_rise  = sys_cyc;
        tms_log    = {tms_log[6:0], tms_o};
    end

    // Behavioural target TAP: 8-bit IR, IDCODE (32 bit) and BYPASS (1 bit).
    typedef enum int {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap = TLR;
    logic [7:0]  ir_reg = INS_IDCODE;
    logic [7:0]  ir_sr = 8'h00;
    logic [31:0] dr_sr = 32'h0;
    logic        byp = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic t);
        case (s)
            TLR:     return t ? TLR    : RTI;
            RTI:     return t ? SEL_DR : RTI;
            SEL_DR:  return t ? SEL_IR : CAP_DR;
            CAP_DR:  return t ? EX1_DR : SH_DR;
            SH_DR:   return t ? EX1_DR : SH_DR;
            EX1_DR:  return t ? UPD_DR : PAU_DR;
            PAU_DR:  return t ? EX2_DR : PAU_DR;
            EX2_DR:  return t ? UPD_DR : SH_DR;
            UPD_DR:  return t ? SEL_DR : RTI;
            SEL_IR:  return t ? TLR    : CAP_IR;
            CAP_IR:  return t ? EX1_IR : SH_IR;
            SH_IR:   return t ? EX1_IR : SH_IR;
            EX1_IR:  return t ? UPD_IR : PAU_IR;
            PAU_IR:  return t ? EX2_IR : PAU_IR;
            EX2_IR:  return t ? UPD_IR : SH_IR;
            default: return t ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap)
            TLR:    ir_reg = INS_IDCODE;
            CAP_DR: begin dr_sr = IDCODE; byp = 1'b0; end
            SH_DR:  if (ir_reg == INS_IDCODE) dr_sr = {tdi_o, dr_sr[31:1]};
                    else byp = tdi_o;
            CAP_IR: ir_sr = 8'h01;
            SH_IR:  ir_sr = {tdi_o, ir_sr[7:1]};
            UPD_IR: ir_reg = ir_sr;
            default: ;
        endcase
        tap = tap_next(tap, tms_o);
    end

    always @(negedge tck_o) begin
        if (tap == SH_DR)      tdo_i = (ir_reg == INS_IDCODE) ? dr_sr[0] : byp;
        else if (tap == SH_IR) tdo_i = ir_sr[0];
        else                   tdo_i = 1'b0;
    end

    function automatic logic [31:0] len_mask(input int l);
        if (l >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << l) - 32'd1;
    endfunction

    // Issue one command, wait for its response and compare everything.
    task automatic run_cmd(input string tag, input logic rst, input logic ir,
                           input logic [LEN_W-1:0] len, input logic [31:0] data,
                           input logic e_err, input logic [31:0] e_data, input int e_tck);
        int start_tck;
        int waited;
        bit got;
        @(negedge sys_clk);
        cmd_reset = rst; cmd_ir = ir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
        end
        check($sformatf("%s_ready", tag), cmd_ready, 1'b1);
        @(posedge sys_clk);
        start_tck = tck_total;
        #1 cmd_valid = 1'b0;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        check($sformatf("%s_rsp_valid", tag), got, 1'b1);
        check($sformatf("%s_rsp_err", tag), rsp_err, e_err);
        check($sformatf("%s_rsp_data", tag), rsp_data, e_data);
        check($sformatf("%s_tck_count", tag), tck_total - start_tck, e_tck);
        check($sformatf("%s_ready_at_rsp", tag), cmd_ready, 1'b1);
        check($sformatf("%s_tap_rti", tag), tap == RTI, 1'b1);
        if (e_err) check($sformatf("%s_err_latency", tag), waited, 1);
    endtask

    // Release reset and check the automatic TAP reset sequence.
    task automatic release_and_check(input string tag);
        int rel_cyc;
        int rel_tck;
        int pulses;
        int waited;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rel_cyc = sys_cyc;
        rel_tck = tck_total;
        pulses  = rsp_pulses;
        waited  = 0;
        @(negedge sys_clk);
        while (cmd_ready !== 1'b1 && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
        end
        check($sformatf("%s_ready_cycles", tag), sys_cyc - rel_cyc, 6 * 2 * CLK_DIV);
        check($sformatf("%s_tck_count", tag), tck_total - rel_tck, 6);
        check($sformatf("%s_tck_period", tag), tck_period, 2 * CLK_DIV);
        check($sformatf("%s_tms_seq", tag), tms_log[5:0], 6'b111110);
        check($sformatf("%s_tap_rti", tag), tap == RTI, 1'b1);
        check($sformatf("%s_no_rsp", tag), rsp_pulses - pulses, 0);
        check($sformatf("%s_busy", tag), busy, 1'b0);
    endtask

    typedef struct {
        logic        rst;
        logic        ir;
        logic [5:0]  len;
        logic [31:0] data;
        logic        e_err;
        logic [31:0] e_data;
        int          e_tck;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ir_idcode;
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0]  ins;
        logic [5:0]  l;
        int          start_tck;
        int          r1;
        int          waited;
        int          pulses;
        bit          got;

        //            rst   ir    len    data          err   exp data      tck
        vecs[0] = '{1'b0, 1'b1, 6'd8,  32'h11,       1'b0, 32'h01,       14};
        vecs[1] = '{1'b0, 1'b0, 6'd32, 32'h0,        1'b0, IDCODE,       37};
        vecs[2] = '{1'b0, 1'b1, 6'd8,  32'hFF,       1'b0, 32'h01,       14};
        vecs[3] = '{1'b0, 1'b0, 6'd8,  32'hA5,       1'b0, 32'h4A,       13};
        vecs[4] = '{1'b0, 1'b0, 6'd0,  32'hFFFF,     1'b1, 32'h0,        0};
        vecs[5] = '{1'b0, 1'b0, 6'd33, 32'hFFFF,     1'b1, 32'h0,        0};
        vecs[6] = '{1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0,        6};
        vecs[7] = '{1'b0, 1'b0, 6'd16, 32'h0,        1'b0, 32'h481B,     21};
        vecs[8] = '{1'b0, 1'b0, 6'd1,  32'h1,        1'b0, 32'h1,        6};
        vecs[9] = '{1'b0, 1'b1, 6'd63, 32'h5,        1'b1, 32'h0,        0};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_tck", tck_o, 1'b0);
        check("rst_tms", tms_o, 1'b1);
        check("rst_tdi", tdi_o, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        release_and_check("por");

        for (int i = 0; i < 10; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ir, vecs[i].len,
                    vecs[i].data, vecs[i].e_err, vecs[i].e_data, vecs[i].e_tck);

        // Reset in the middle of a 32-bit DR scan, during bit 10.
        @(negedge sys_clk);
        cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 6'd32; cmd_data = $urandom; cmd_valid = 1'b1;
        @(posedge sys_clk);
        start_tck = tck_total;
        #1 cmd_valid = 1'b0;
        waited = 0;
        while (tck_total - start_tck < 14 && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
        end
        check("midrst_reached_bit10", tck_total - start_tck, 14);
        @(negedge sys_clk);
        pulses = rsp_pulses;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_tck", tck_o, 1'b0);
        check("midrst_tms", tms_o, 1'b1);
        check("midrst_ready", cmd_ready, 1'b0);
        check("midrst_busy", busy, 1'b1);
        repeat (5) @(negedge sys_clk);
        check("midrst_no_rsp_in_reset", rsp_pulses - pulses, 0);
        release_and_check("midrst");
        run_cmd("midrst_dr", 1'b0, 1'b0, 6'd32, 32'h0, 1'b0, IDCODE, 37);

        // Back-to-back: cmd_valid held, second command taken in the rsp cycle.
        run_cmd("b2b_ir", 1'b0, 1'b1, 6'd8, 32'(INS_BYPASS), 1'b0, 32'h01, 14);
        d = 32'($urandom_range(0, 255));
        e = (d << 1) & 32'hFF;
        @(negedge sys_clk);
        cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 6'd8; cmd_data = d; cmd_valid = 1'b1;
        @(posedge sys_clk);
        start_tck = tck_total;
        waited = 0; got = 1'b0;
        while (!got && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        r1 = sys_cyc;
        check("b2b_rsp1_valid", got, 1'b1);
        check("b2b_rsp1_data", rsp_data, e);
        check("b2b_rsp1_ready", cmd_ready, 1'b1);
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        @(negedge sys_clk);
        check("b2b_second_accepted", busy, 1'b1);
        waited = 0; got = 1'b0;
        while (!got && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        check("b2b_rsp2_valid", got, 1'b1);
        check("b2b_rsp2_data", rsp_data, e);
        check("b2b_rsp_gap", sys_cyc - r1, 13 * 2 * CLK_DIV + 1);
        check("b2b_tck_total", tck_total - start_tck, 26);

        // Randomized commands against the bench's own model of the target.
        ir_idcode = 1'b0;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    case ($urandom_range(0, 2))
                        0:       ins = INS_IDCODE;
                        1:       ins = INS_BYPASS;
                        default: ins = 8'($urandom);
                    endcase
                    run_cmd($sformatf("rnd%0d_ir", i), 1'b0, 1'b1, 6'd8, 32'(ins), 1'b0, 32'h01, 14);
                    ir_idcode = (ins == INS_IDCODE);
                end
                7: begin
                    l = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
                    run_cmd($sformatf("rnd%0d_bad", i), 1'b0, 1'($urandom), l, $urandom, 1'b1, 32'h0, 0);
                end
                8: begin
                    run_cmd($sformatf("rnd%0d_rst", i), 1'b1, 1'b0, 6'($urandom), $urandom, 1'b0, 32'h0, 6);
                    ir_idcode = 1'b1;
                end
                default: begin
                    l = 6'($urandom_range(1, 32));
                    d = $urandom;
                    e = ir_idcode ? (IDCODE & len_mask(int'(l))) : ((d << 1) & len_mask(int'(l)));
                    run_cmd($sformatf("rnd%0d_dr", i), 1'b0, 1'b0, l, d, 1'b0, e, int'(l) + 5);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
